// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types for the alu_pipe block: opcode encoding, flag bundle,
//   control-state encoding and bit positions of each flag on the Flags bus.
//   Used by alu_pipe and its testbench. The multiply opcode only executes
//   when the design is built with ALU_MUL_EN defined.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_SRA = 4'd8,
    OP_MUL = 4'd9
  } alu_op_t;

  // Field order gives the Flags bus layout {err, n, z, c, v}.
  typedef struct packed {
    logic err;
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } alu_state_t;

  localparam int FLAG_ERR = 4;
  localparam int FLAG_N   = 3;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter
//   Iterative shift-add multiplier returning the low WIDTH bits of the
//   unsigned product. A start pulse loads the operands; one partial product
//   is accumulated per clock for WIDTH clocks. 'done' is high during the
//   final step and 'product' then carries the completed value, so the
//   consumer can capture the result on the same edge that finishes it.
//   Ports:
//     clk      rising-edge clock
//     rst_n    asynchronous active-low reset (clears all state)
//     start    load a, b and begin (ignored by design while busy)
//     a, b     multiplicand / multiplier
//     done     final step in progress this cycle
//     product  low WIDTH bits of a*b, valid while done is high
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] acc_next;

  // Only the low WIDTH product bits are kept, so the multiplicand may
  // simply shift its top bits away.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = (count_reg == CW'(1));
  assign product  = acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= a;
      mplier_reg <= b;
      count_reg  <= CW'(WIDTH);
    end else if (count_reg != '0) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      count_reg  <= count_reg - CW'(1);
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe
//   Handshaked WIDTH-bit ALU with a registered result and status flags.
//   Single-cycle ops complete on the edge that accepts them; a full output
//   register that is being taken on the same edge is reloaded without a
//   bubble. Configuration macro ALU_MUL_EN adds an iterative multiply
//   (opcode 9, WIDTH cycles); without it opcode 9 is reported as illegal.
//   Ports:
//     Clk        rising-edge clock
//     Rst_n      asynchronous active-low reset
//     In_Valid   operation presented
//     In_Ready   operation can be accepted this cycle
//     Op         opcode (alu_pkg::alu_op_t)
//     ArgA/ArgB  operands; shifts use ArgB[SHW-1:0]
//     Out_Valid  Result/Flags valid, held until taken
//     Out_Ready  consumer takes the result
//     Result     operation result
//     Flags      {Err, N, Z, C, V}
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [3:0]       Op,
  input  logic [WIDTH-1:0] ArgA,
  input  logic [WIDTH-1:0] ArgB,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Result,
  output logic [4:0]       Flags
);

  localparam int SHW = $clog2(WIDTH);

  // Held low through reset and for the first clock after release so the
  // upstream stage never sees a ready that coincides with reset removal.
  logic             ready_reg;
  alu_state_t       state_cur;

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  alu_flags_t       flags_reg;

  logic             in_fire;
  logic             out_fire;
  logic             is_mul;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flg;

  logic             load_en;
  logic [WIDTH-1:0] load_res;
  alu_flags_t       load_flg;

  assign In_Ready = ready_reg && (state_cur == ST_IDLE) && (!out_valid_reg || Out_Ready);
  assign in_fire  = In_Valid && In_Ready;
  assign out_fire = out_valid_reg && Out_Ready;

  // Combinational op mux, arithmetic carried at WIDTH+1 bits.
  always_comb begin
    add_full = {1'b0, ArgA} + {1'b0, ArgB};
    sub_full = {1'b0, ArgA} + {1'b0, ~ArgB} + {{WIDTH{1'b0}}, 1'b1};
    alu_res  = '0;
    alu_flg  = '0;
    case (Op)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_flg.c = add_full[WIDTH];
        alu_flg.v = (ArgA[WIDTH-1] == ArgB[WIDTH-1]) && (add_full[WIDTH-1] != ArgA[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = sub_full[WIDTH-1:0];
        alu_flg.c = sub_full[WIDTH];
        alu_flg.v = (ArgA[WIDTH-1] != ArgB[WIDTH-1]) && (sub_full[WIDTH-1] != ArgA[WIDTH-1]);
      end
      OP_AND: alu_res = ArgA & ArgB;
      OP_OR:  alu_res = ArgA | ArgB;
      OP_XOR: alu_res = ArgA ^ ArgB;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(ArgA) < $signed(ArgB))};
      OP_SLL: alu_res = ArgA << ArgB[SHW-1:0];
      OP_SRL: alu_res = ArgA >> ArgB[SHW-1:0];
      OP_SRA: alu_res = $unsigned($signed(ArgA) >>> ArgB[SHW-1:0]);
`ifdef ALU_MUL_EN
      // Result comes from the multiplier; this path is never loaded.
      OP_MUL: alu_res = '0;
`endif
      default: alu_flg.err = 1'b1;
    endcase
    if (!alu_flg.err) begin
      alu_flg.n = alu_res[WIDTH-1];
      alu_flg.z = (alu_res == '0);
    end
  end

`ifdef ALU_MUL_EN
  alu_state_t       state_reg;
  alu_state_t       state_next;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign is_mul    = (Op == OP_MUL);
  assign state_cur = state_reg;

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .start   (mul_start),
    .a       (ArgA),
    .b       (ArgB),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    mul_start  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (in_fire && is_mul) begin
          state_next = ST_MUL_BUSY;
          mul_start  = 1'b1;
        end
      end
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end
`else
  assign is_mul    = 1'b0;
  assign state_cur = ST_IDLE;
`endif

  // A multiply start does not touch the output register, so a pending
  // result may drain on the same edge that launches the multiply.
  always_comb begin
    load_en  = in_fire && !is_mul;
    load_res = alu_res;
    load_flg = alu_flg;
`ifdef ALU_MUL_EN
    if (mul_done) begin
      load_en      = 1'b1;
      load_res     = mul_prod;
      load_flg     = '0;
      load_flg.n   = mul_prod[WIDTH-1];
      load_flg.z   = (mul_prod == '0);
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ready_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      flags_reg     <= '0;
    end else begin
      ready_reg <= 1'b1;
      if (load_en) begin
        out_valid_reg <= 1'b1;
        result_reg    <= load_res;
        flags_reg     <= load_flg;
      end else if (out_fire) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign Out_Valid       = out_valid_reg;
  assign Result          = result_reg;
  assign Flags[FLAG_ERR] = flags_reg.err;
  assign Flags[FLAG_N]   = flags_reg.n;
  assign Flags[FLAG_Z]   = flags_reg.z;
  assign Flags[FLAG_C]   = flags_reg.c;
  assign Flags[FLAG_V]   = flags_reg.v;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe
//   Directed self-checking bench for alu_pipe at WIDTH = 32. Covers reset
//   state, each op class with hand-computed results and flags, a
//   back-to-back stream, an output stall, illegal opcodes and reset while
//   an operation is outstanding. Multiply cases are built when ALU_MUL_EN
//   is defined; otherwise opcode 9 is checked as illegal.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             Clk;
  logic             Rst_n;
  logic             In_Valid;
  logic             In_Ready;
  logic [3:0]       Op;
  logic [WIDTH-1:0] ArgA;
  logic [WIDTH-1:0] ArgB;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Result;
  logic [4:0]       Flags;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  alu_pipe #(
    .WIDTH (WIDTH)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .Op        (Op),
    .ArgA      (ArgA),
    .ArgB      (ArgB),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Result    (Result),
    .Flags     (Flags)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One single-cycle op: accept, check the registered result, then drain.
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic [4:0] ef);
    Op = op; ArgA = a; ArgB = b; In_Valid = 1'b1; Out_Ready = 1'b1;
    #1;
    check({tag, "_rdy"}, In_Ready, 1);
    step();
    In_Valid = 1'b0;
    $display("%s op=%0d a=%h b=%h -> res=%h flags=%b", tag, op, a, b, Result, Flags);
    check({tag, "_ov"}, Out_Valid, 1);
    check({tag, "_res"}, Result, er);
    check({tag, "_flg"}, Flags, ef);
    step();
    check({tag, "_drain"}, Out_Valid, 0);
  endtask

`ifdef ALU_MUL_EN
  // Multiply: busy for WIDTH edges with no output and no ready, result
  // appears after the WIDTH-th edge following the accept.
  task automatic mul_case(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [4:0] ef);
    logic bad;
    Op = OP_MUL; ArgA = a; ArgB = b; In_Valid = 1'b1; Out_Ready = 1'b1;
    #1;
    check({tag, "_rdy"}, In_Ready, 1);
    step();
    In_Valid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < WIDTH; c++) begin
      bad = bad | Out_Valid | In_Ready;
      step();
    end
    $display("%s op=%0d a=%h b=%h -> res=%h flags=%b", tag, OP_MUL, a, b, Result, Flags);
    check({tag, "_busy"}, bad, 0);
    check({tag, "_ov"}, Out_Valid, 1);
    check({tag, "_res"}, Result, er);
    check({tag, "_flg"}, Flags, ef);
    step();
    check({tag, "_drain"}, Out_Valid, 0);
  endtask
`endif

  initial begin
    logic bad;
    Rst_n = 1'b0; In_Valid = 1'b0; Out_Ready = 1'b0;
    Op = 4'd0; ArgA = '0; ArgB = '0;

    // Reset state
    step(); step();
    check("rst_ov", Out_Valid, 0);
    check("rst_res", Result, 0);
    check("rst_flg", Flags, 0);
    Rst_n = 1'b1;
    #1;
    check("rst_rdy_before", In_Ready, 0);
    step();
    check("rst_rdy_after", In_Ready, 1);

    // Single-cycle ops; flags are {err,n,z,c,v}
    single("add1",  OP_ADD, 32'h01234567, 32'h89ABCDEF, 32'h8ACF1356, 5'b01000);
    single("add2",  OP_ADD, 32'h80000000, 32'h80000000, 32'h00000000, 5'b00111);
    single("add3",  OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFE, 5'b01001);
    single("sub1",  OP_SUB, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 5'b00011);
    single("sub2",  OP_SUB, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 5'b01000);
    single("slt1",  OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 5'b00000);
    single("slt2",  OP_SLT, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 5'b00100);
    single("sra",   OP_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 5'b01000);
    single("sll",   OP_SLL, 32'h00000001, 32'h0000003F, 32'h80000000, 5'b01000);
    single("srl",   OP_SRL, 32'h80000000, 32'h00000024, 32'h08000000, 5'b00000);
    single("and",   OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 5'b00100);
    single("or",    OP_OR,  32'h12340000, 32'h00005678, 32'h12345678, 5'b00000);
    single("xor",   OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 5'b01000);
    single("ill15", 4'd15,  32'h12345678, 32'h9ABCDEF0, 32'h00000000, 5'b10000);
`ifndef ALU_MUL_EN
    single("op9",   4'd9,   32'h00000006, 32'h00000007, 32'h00000000, 5'b10000);
`endif

    // Back-to-back stream of 8 ADDs
    Out_Ready = 1'b1; In_Valid = 1'b1; Op = OP_ADD; ArgB = 32'h100;
    for (int i = 0; i < 8; i++) begin
      ArgA = i;
      #1;
      check("strm_rdy", In_Ready, 1);
      step();
      $display("strm item %0d -> res=%h", i, Result);
      check("strm_ov", Out_Valid, 1);
      check("strm_res", Result, 32'h100 + i);
    end
    In_Valid = 1'b0;
    step();
    check("strm_end", Out_Valid, 0);

    // Output stall for 3 cycles mid-stream
    In_Valid = 1'b1; ArgB = 32'h0; ArgA = 32'h200;
    step();
    check("stl_r0", Result, 32'h200);
    ArgA = 32'h201;
    step();
    check("stl_r1", Result, 32'h201);
    Out_Ready = 1'b0; ArgA = 32'h202;
    #1;
    check("stl_rdy_lo", In_Ready, 0);
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      bad = bad | !Out_Valid | In_Ready | (Result != 32'h201);
    end
    $display("stall held res=%h", Result);
    check("stl_hold", bad, 0);
    Out_Ready = 1'b1;
    #1;
    check("stl_rdy_hi", In_Ready, 1);
    step();
    check("stl_r2", Result, 32'h202);
    ArgA = 32'h203;
    step();
    check("stl_r3", Result, 32'h203);
    In_Valid = 1'b0;
    step();
    check("stl_end", Out_Valid, 0);

`ifdef ALU_MUL_EN
    mul_case("mul67", 32'h00000006, 32'h00000007, 32'd42, 5'b00000);
    mul_case("mulff", 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 5'b01000);

    // Multiply launched while a held result drains on the same edge
    Op = OP_ADD; ArgA = 32'd2; ArgB = 32'd3; In_Valid = 1'b1; Out_Ready = 1'b0;
    step();
    In_Valid = 1'b0;
    check("pend_res", Result, 32'd5);
    mul_case("muldrn", 32'h00000003, 32'h00000005, 32'd15, 5'b00000);

    // Reset at cycle 10 of a multiply: abandoned, no output
    Op = OP_MUL; ArgA = 32'd9; ArgB = 32'd9; In_Valid = 1'b1; Out_Ready = 1'b1;
    step();
    In_Valid = 1'b0;
    repeat (10) step();
    Rst_n = 1'b0;
    #1;
    check("mrst_ov", Out_Valid, 0);
    step();
    Rst_n = 1'b1;
    #1;
    check("mrst_rdy_before", In_Ready, 0);
    step();
    check("mrst_rdy_after", In_Ready, 1);
    bad = 1'b0;
    for (int i = 0; i < WIDTH + 8; i++) begin
      bad = bad | Out_Valid;
      step();
    end
    $display("mul reset: abandoned op produced no output");
    check("mrst_no_out", bad, 0);
`else
    // Reset while a result is held: output cleared immediately
    Op = OP_ADD; ArgA = 32'd1; ArgB = 32'd1; In_Valid = 1'b1; Out_Ready = 1'b0;
    step();
    In_Valid = 1'b0;
    check("hrst_pre", Out_Valid, 1);
    Rst_n = 1'b0;
    #1;
    check("hrst_ov", Out_Valid, 0);
    check("hrst_res", Result, 0);
    step();
    Rst_n = 1'b1;
    #1;
    check("hrst_rdy_before", In_Ready, 0);
    step();
    check("hrst_rdy_after", In_Ready, 1);
    check("hrst_ov_after", Out_Valid, 0);
`endif

    // Normal operation after reset
    single("post", OP_ADD, 32'h00000010, 32'h00000020, 32'h00000030, 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
